// File: rtl/slice_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : slice_serial_comparator
// Description : Bit-serial magnitude comparator sequencer. Feeds operand bit
//               pairs MSB-first to one external 2-bit comparator slice and
//               stops at the first unequal pair. Results are returned over a
//               valid/ready handshake as gt/lt/eq, or err when the slice
//               asserts g and l together.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    // operand input handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    // drives to the external 2-bit comparator slice
    output logic             sa1,
    output logic             sa0,
    output logic             sb1,
    output logic             sb0,
    // slice outcome for the current pair
    input  logic             sg,
    input  logic             sl,
    // result handshake
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             err
);

    // Number of 2-bit beats per operation and the beat counter sizing.
    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(N - 1);

    // An odd or too-narrow operand cannot be split into whole pairs.
    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("slice_serial_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;

    // Operands after discarding the pair currently on the slice.
    logic [WIDTH-1:0] w_next_a;
    logic [WIDTH-1:0] w_next_b;

    // Advance both operand registers by one pair, zero filling from the right.
    always_comb begin
        w_next_a = r_sh_a << 2;
        w_next_b = r_sh_b << 2;
    end

    // Sequencer: accept operands, step pairs through the slice, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            err       <= 1'b0;
            sa1       <= 1'b0;
            sa0       <= 1'b0;
            sb1       <= 1'b0;
            sb0       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_sh_a   <= a;
                        r_sh_b   <= b;
                        r_cnt    <= '0;
                        // Present the most significant pair straight away so
                        // the first sample happens on the very next edge.
                        sa1      <= a[WIDTH-1];
                        sa0      <= a[WIDTH-2];
                        sb1      <= b[WIDTH-1];
                        sb0      <= b[WIDTH-2];
                        in_ready <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (sg && sl) begin
                        // Contradictory slice answer: report it alone.
                        err       <= 1'b1;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        eq        <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (sg) begin
                        gt        <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (sl) begin
                        lt        <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_cnt == C_LAST_BEAT) begin
                        // Every pair matched.
                        eq        <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_sh_a <= w_next_a;
                        r_sh_b <= w_next_b;
                        r_cnt  <= r_cnt + CW'(1);
                        sa1    <= w_next_a[WIDTH-1];
                        sa0    <= w_next_a[WIDTH-2];
                        sb1    <= w_next_b[WIDTH-1];
                        sb0    <= w_next_b[WIDTH-2];
                    end
                end

                S_DONE: begin
                    // Result is held untouched until downstream takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        eq        <= 1'b0;
                        err       <= 1'b0;
                        sa1       <= 1'b0;
                        sa0       <= 1'b0;
                        sb1       <= 1'b0;
                        sb0       <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slice_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_serial_comparator
// Description : Directed bench for slice_serial_comparator with a behavioural
//               2-bit comparator slice (and a g=l=1 stub mode), plus a WIDTH=2
//               instance for the single-beat corner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_serial_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=8 instance
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sa1, sa0, sb1, sb0;
    logic       sg, sl;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       gt, lt, eq, err;
    logic       stub = 1'b0;

    // WIDTH=2 instance
    logic       d2_in_valid = 1'b0;
    logic       d2_in_ready;
    logic [1:0] d2_a = '0;
    logic [1:0] d2_b = '0;
    logic       d2_sa1, d2_sa0, d2_sb1, d2_sb0;
    logic       d2_sg, d2_sl;
    logic       d2_out_valid;
    logic       d2_out_ready = 1'b0;
    logic       d2_gt, d2_lt, d2_eq, d2_err;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    // Behavioural comparator slices; the stub forces g=l=1.
    assign sg    = stub | ({sa1, sa0} > {sb1, sb0});
    assign sl    = stub | ({sa1, sa0} < {sb1, sb0});
    assign d2_sg = {d2_sa1, d2_sa0} > {d2_sb1, d2_sb0};
    assign d2_sl = {d2_sa1, d2_sa0} < {d2_sb1, d2_sb0};

    slice_serial_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sa1(sa1), .sa0(sa0), .sb1(sb1), .sb0(sb0),
        .sg(sg), .sl(sl),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .lt(lt), .eq(eq), .err(err)
    );

    slice_serial_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a(d2_a), .b(d2_b),
        .sa1(d2_sa1), .sa0(d2_sa0), .sb1(d2_sb1), .sb0(d2_sb0),
        .sg(d2_sg), .sl(d2_sl),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .gt(d2_gt), .lt(d2_lt), .eq(d2_eq), .err(d2_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flags();
        return {4'b0, gt, lt, eq, err};
    endfunction

    function automatic logic [7:0] drives();
        return {4'b0, sa1, sa0, sb1, sb0};
    endfunction

    // Present one operand pair for a single cycle; returns #1 after edge 0.
    task automatic start(input logic [7:0] va, input logic [7:0] vb);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; 99 if it never comes.
    task automatic wait_valid(output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, {7'b0, out_valid}, 8'h00);
        check({tag, "_ir_set"}, {7'b0, in_ready}, 8'h01);
        check({tag, "_flags_clr"}, flags(), 8'h00);
        check({tag, "_drv_clr"}, drives(), 8'h00);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {7'b0, in_ready}, 8'h01);
        check("rst_out_valid", {7'b0, out_valid}, 8'h00);
        check("rst_flags", flags(), 8'h00);
        check("rst_drives", drives(), 8'h00);

        // 1: A5 vs 5A, first pair 10 vs 01 -> gt after edge 1
        start(8'hA5, 8'h5A);
        check("t1_in_ready_low", {7'b0, in_ready}, 8'h00);
        check("t1_beat1_drv", drives(), 8'b0000_1001);
        wait_valid(lat);
        check("t1_latency", 8'(lat), 8'd1);
        check("t1_flags", flags(), 8'b0000_1000);
        handshake("t1");

        // 2: 3C vs 3C, pairs 00,11,11,00 -> eq after edge 4
        start(8'h3C, 8'h3C);
        check("t2_beat1_drv", drives(), 8'b0000_0000);
        @(posedge clk); #1;
        check("t2_beat2_drv", drives(), 8'b0000_1111);
        check("t2_busy_b2", {7'b0, out_valid}, 8'h00);
        @(posedge clk); #1;
        check("t2_beat3_drv", drives(), 8'b0000_1111);
        @(posedge clk); #1;
        check("t2_beat4_drv", drives(), 8'b0000_0000);
        check("t2_busy_b4", {7'b0, out_valid}, 8'h00);
        @(posedge clk); #1;
        check("t2_valid_edge4", {7'b0, out_valid}, 8'h01);
        check("t2_flags", flags(), 8'b0000_0010);
        handshake("t2");

        // 3: 12 vs 13 -> lt after edge 4, then FF vs 00 on first IDLE cycle
        start(8'h12, 8'h13);
        wait_valid(lat);
        check("t3_latency", 8'(lat), 8'd4);
        check("t3_flags", flags(), 8'b0000_0100);
        handshake("t3");
        start(8'hFF, 8'h00);
        check("t3b_accepted", {7'b0, in_ready}, 8'h00);
        wait_valid(lat);
        check("t3b_latency", 8'(lat), 8'd1);
        check("t3b_flags", flags(), 8'b0000_1000);
        handshake("t3b");

        // 4: stall output for 5 cycles with ignored in_valid pulses
        start(8'hA5, 8'h5A);
        wait_valid(lat);
        check("t4_latency", 8'(lat), 8'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'h00;
            b = 8'hFF;
            @(posedge clk); #1;
            check("t4_hold_ov", {7'b0, out_valid}, 8'h01);
            check("t4_hold_flags", flags(), 8'b0000_1000);
            check("t4_hold_ir", {7'b0, in_ready}, 8'h00);
        end
        in_valid = 1'b0;
        handshake("t4");
        @(posedge clk); #1;
        check("t4_no_spurious", {7'b0, out_valid}, 8'h00);

        // 5: reset during beat 2 discards the operation
        start(8'h01, 8'h02);
        @(posedge clk); #1;
        check("t5_beat2_drv", drives(), 8'b0000_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_ir", {7'b0, in_ready}, 8'h01);
        check("t5_rst_ov", {7'b0, out_valid}, 8'h00);
        check("t5_rst_flags", flags(), 8'h00);
        check("t5_rst_drv", drives(), 8'h00);
        repeat (4) begin
            @(posedge clk); #1;
            check("t5_idle_ov", {7'b0, out_valid}, 8'h00);
        end
        start(8'h01, 8'h02);
        wait_valid(lat);
        check("t5_latency", 8'(lat), 8'd4);
        check("t5_flags", flags(), 8'b0000_0100);
        handshake("t5");

        // 6a: stub slice asserts g and l together -> err after edge 1
        stub = 1'b1;
        start(8'h33, 8'h33);
        wait_valid(lat);
        check("t6_latency", 8'(lat), 8'd1);
        check("t6_flags", flags(), 8'b0000_0001);
        stub = 1'b0;
        handshake("t6");

        // 6b: WIDTH=2, 10 vs 10 -> eq after edge 1
        d2_a = 2'b10;
        d2_b = 2'b10;
        d2_in_valid = 1'b1;
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        check("t6b_drv", {4'b0, d2_sa1, d2_sa0, d2_sb1, d2_sb0}, 8'b0000_1010);
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (d2_out_valid) begin
                lat = k;
                break;
            end
        end
        check("t6b_latency", 8'(lat), 8'd1);
        check("t6b_flags", {4'b0, d2_gt, d2_lt, d2_eq, d2_err}, 8'b0000_0010);
        d2_out_ready = 1'b1;
        @(posedge clk); #1;
        d2_out_ready = 1'b0;
        check("t6b_ov_clr", {7'b0, d2_out_valid}, 8'h00);
        check("t6b_ir_set", {7'b0, d2_in_ready}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
